// File: rtl/flow_dma_pkg.sv
// Shared definitions for the batch mover: FSM states, record field positions
// and defaults for the marker and success values.
package flow_dma_pkg;

    typedef enum logic [2:0] {
        ST_POLL,
        ST_REC_HDR,
        ST_STREAM,
        ST_WAIT_CALC,
        ST_CLEAR
    } state_t;

    localparam int MARK_LSB    = 0;
    localparam int FLOWNUM_LSB = 16;
    localparam int LEN_LSB     = 32;

    localparam logic [7:0]  DEF_START_MARK      = 8'h55;
    localparam logic [63:0] DEF_SUCCESS_PATTERN = 64'hFFFF_FFFF_FFFF_FFFE;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = 2;
    localparam int FIFO_CNT_W = 3;

endpackage

// File: rtl/fdma_prefetch_fifo.sv
// Four-entry prefetch FIFO holding payload words tagged with their last flag.
// Storage is not reset; only pointers and occupancy are.
module fdma_prefetch_fifo
    import flow_dma_pkg::*;
#(
    parameter int WIDTH = 65
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  full,
    output logic                  empty
);

    logic [WIDTH-1:0]      mem [0:FIFO_DEPTH-1];
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_PTR_W-1:0] rd_ptr;

    // Data storage: written on push, never cleared
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/flow_batch_dma.sv
// Batch mover: polls a BRAM mailbox, streams each record's payload to the
// entropy engine through a small prefetch FIFO, writes results back into a
// ring of result words and finally releases the mailbox.
module flow_batch_dma
    import flow_dma_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 64,
    parameter int                    DATA_DEPTH      = 65536,
    parameter int                    PAYLOAD_WORDS   = 7,
    parameter int                    PKTS_PER_FLOW   = 5,
    parameter int                    RESULT_BASE     = DATA_DEPTH - 4,
    parameter int                    RESULT_WORDS    = 4,
    parameter logic [7:0]            START_MARK      = DEF_START_MARK,
    parameter logic [DATA_WIDTH-1:0] SUCCESS_PATTERN = DATA_WIDTH'(DEF_SUCCESS_PATTERN),
    localparam int                   AW              = $clog2(DATA_DEPTH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [DATA_WIDTH-1:0]   i_bram_dout,
    output logic [AW-1:0]           o_bram_addr,
    output logic [DATA_WIDTH-1:0]   o_bram_din,
    output logic                    o_bram_en,
    output logic [DATA_WIDTH/8-1:0] o_bram_we,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_data_valid,
    input  logic                    i_data_ready,
    output logic                    o_data_last,
    output logic [7:0]              o_data_len,
    output logic [7:0]              o_flow_idx,
    output logic [15:0]             o_flow_num,
    input  logic                    i_result_valid,
    input  logic [DATA_WIDTH-1:0]   i_result,
    input  logic                    i_calc_complete,
    output logic                    o_busy,
    output logic                    o_error,
    output logic                    o_success
);

    localparam logic [3:0]  PW_LAST  = 4'(PAYLOAD_WORDS - 1);
    localparam logic [3:0]  PW_CNT   = 4'(PAYLOAD_WORDS);
    localparam logic [3:0]  PPF_LAST = 4'(PKTS_PER_FLOW - 1);
    localparam logic [AW:0] STRIDE   = (AW+1)'(PAYLOAD_WORDS + 1);
    localparam logic [7:0]  RES_MASK = 8'(RESULT_WORDS - 1);

    state_t                state, state_nxt;
    logic                  poll_pend, hdr_pend;
    logic [AW:0]           rec_addr, rec_end;
    logic [3:0]            rd_cnt, pkt_in_flow;
    logic                  rd_issue, rd_last;
    logic                  rd_vld_p1, rd_last_p1;
    logic [15:0]           pkt_idx, n_pkts;
    logic [7:0]            flow_idx, flow_num_q, res_idx, data_len;
    logic                  calc_q, error_q, success_q;
    logic                  bram_en, we_all, hdr_ok, fifo_room, accept, last_acc;
    logic [DATA_WIDTH:0]   fifo_head;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  fifo_full, fifo_empty;

    assign rec_end   = rec_addr + (AW+1)'(PAYLOAD_WORDS);
    assign hdr_ok    = (i_bram_dout[MARK_LSB +: 8] == START_MARK) &&
                       (rec_end < (AW+1)'(RESULT_BASE));
    assign fifo_room = !fifo_full &&
                       (({1'b0, fifo_count} + {3'b000, rd_vld_p1}) < 4'(FIFO_DEPTH));
    assign accept    = o_data_valid && i_data_ready;
    assign last_acc  = accept && fifo_head[DATA_WIDTH];

    // Next-state and BRAM port B request decode
    always_comb begin
        state_nxt   = state;
        bram_en     = 1'b0;
        we_all      = 1'b0;
        o_bram_addr = '0;
        o_bram_din  = '0;
        rd_issue    = 1'b0;
        rd_last     = 1'b0;
        case (state)
            ST_POLL: begin
                if (!poll_pend) begin
                    bram_en = 1'b1;
                end else if (i_bram_dout[MARK_LSB +: 8] == START_MARK) begin
                    state_nxt = ST_REC_HDR;
                end
            end
            ST_REC_HDR: begin
                if (!hdr_pend) begin
                    bram_en     = 1'b1;
                    o_bram_addr = rec_addr[AW-1:0];
                end else if (!hdr_ok) begin
                    state_nxt = ST_CLEAR;
                end else begin
                    // First payload read overlaps header decode
                    bram_en     = 1'b1;
                    o_bram_addr = rec_addr[AW-1:0] + AW'(1);
                    rd_issue    = 1'b1;
                    rd_last     = (PW_LAST == 4'd0);
                    state_nxt   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if ((rd_cnt < PW_CNT) && fifo_room) begin
                    bram_en     = 1'b1;
                    o_bram_addr = rec_addr[AW-1:0] + AW'(rd_cnt) + AW'(1);
                    rd_issue    = 1'b1;
                    rd_last     = (rd_cnt == PW_LAST);
                end
                if (last_acc) begin
                    state_nxt = (pkt_idx == n_pkts - 16'd1) ? ST_WAIT_CALC : ST_REC_HDR;
                end
            end
            ST_WAIT_CALC: begin
                if (i_result_valid) begin
                    bram_en     = 1'b1;
                    we_all      = 1'b1;
                    o_bram_addr = AW'(RESULT_BASE) + AW'(res_idx & RES_MASK);
                    o_bram_din  = i_result;
                end
                if (calc_q) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                bram_en   = 1'b1;
                we_all    = 1'b1;
                state_nxt = ST_POLL;
            end
            default: state_nxt = ST_POLL;
        endcase
    end

    assign o_bram_en = bram_en && !i_rst;
    assign o_bram_we = {(DATA_WIDTH/8){we_all && !i_rst}};

    // State register, counters and sticky flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_POLL;
            poll_pend   <= 1'b0;
            hdr_pend    <= 1'b0;
            rec_addr    <= (AW+1)'(1);
            rd_cnt      <= '0;
            rd_vld_p1   <= 1'b0;
            rd_last_p1  <= 1'b0;
            pkt_idx     <= '0;
            pkt_in_flow <= '0;
            flow_idx    <= '0;
            flow_num_q  <= '0;
            n_pkts      <= '0;
            res_idx     <= '0;
            calc_q      <= 1'b0;
            data_len    <= '0;
            error_q     <= 1'b0;
            success_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            calc_q     <= i_calc_complete;
            // Read issue -> read data valid at BRAM output
            rd_vld_p1  <= rd_issue;
            rd_last_p1 <= rd_last;
            if (i_result_valid && (i_result == SUCCESS_PATTERN)) success_q <= 1'b1;
            if (rd_issue) rd_cnt <= rd_cnt + 4'd1;
            case (state)
                ST_POLL: begin
                    poll_pend <= !poll_pend;
                    if (poll_pend && (i_bram_dout[MARK_LSB +: 8] == START_MARK)) begin
                        flow_num_q <= i_bram_dout[FLOWNUM_LSB +: 8];
                        n_pkts     <= (16'(i_bram_dout[FLOWNUM_LSB +: 8]) + 16'd1) *
                                      16'(PKTS_PER_FLOW);
                    end
                end
                ST_REC_HDR: begin
                    hdr_pend <= !hdr_pend;
                    if (hdr_pend) begin
                        if (!hdr_ok) error_q  <= 1'b1;
                        else         data_len <= i_bram_dout[LEN_LSB +: 8];
                    end
                end
                ST_STREAM: begin
                    if (last_acc) begin
                        rd_cnt   <= '0;
                        pkt_idx  <= pkt_idx + 16'd1;
                        rec_addr <= rec_addr + STRIDE;
                        if (pkt_in_flow == PPF_LAST) begin
                            pkt_in_flow <= '0;
                            flow_idx    <= flow_idx + 8'd1;
                        end else begin
                            pkt_in_flow <= pkt_in_flow + 4'd1;
                        end
                    end
                end
                ST_WAIT_CALC: begin
                    if (i_result_valid) res_idx <= res_idx + 8'd1;
                end
                ST_CLEAR: begin
                    poll_pend   <= 1'b0;
                    rec_addr    <= (AW+1)'(1);
                    rd_cnt      <= '0;
                    pkt_idx     <= '0;
                    pkt_in_flow <= '0;
                    flow_idx    <= '0;
                    res_idx     <= '0;
                end
                default: ;
            endcase
        end
    end

    fdma_prefetch_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (rd_vld_p1),
        .push_data ({rd_last_p1, i_bram_dout}),
        .pop       (accept),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign o_data_valid = !fifo_empty;
    assign o_data       = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
    assign o_data_last  = !fifo_empty && fifo_head[DATA_WIDTH];
    assign o_data_len   = data_len;
    assign o_flow_idx   = flow_idx;
    assign o_flow_num   = {8'h00, flow_num_q};
    assign o_busy       = (state != ST_POLL);
    assign o_error      = error_q;
    assign o_success    = success_q;

endmodule

// File: tb/tb_flow_batch_dma.sv
// Bench for flow_batch_dma: behavioural BRAM with a host write port, stream
// monitor with stall checks, table of batch scenarios and a reset sequence.
module tb_flow_batch_dma;

    localparam int          PW   = 7;
    localparam int          PPF  = 5;
    localparam logic [63:0] SUCC = 64'hFFFF_FFFF_FFFF_FFFE;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] bram_dout;
    logic [15:0] o_bram_addr;
    logic [63:0] o_bram_din;
    logic        o_bram_en;
    logic [7:0]  o_bram_we;
    logic [63:0] o_data;
    logic        o_data_valid;
    logic        i_data_ready;
    logic        o_data_last;
    logic [7:0]  o_data_len;
    logic [7:0]  o_flow_idx;
    logic [15:0] o_flow_num;
    logic        i_result_valid;
    logic [63:0] i_result;
    logic        i_calc_complete;
    logic        o_busy, o_error, o_success;

    always #5 clk = ~clk;

    flow_batch_dma dut (
        .i_clk(clk), .i_rst(rst), .i_bram_dout(bram_dout),
        .o_bram_addr(o_bram_addr), .o_bram_din(o_bram_din), .o_bram_en(o_bram_en),
        .o_bram_we(o_bram_we), .o_data(o_data), .o_data_valid(o_data_valid),
        .i_data_ready(i_data_ready), .o_data_last(o_data_last), .o_data_len(o_data_len),
        .o_flow_idx(o_flow_idx), .o_flow_num(o_flow_num), .i_result_valid(i_result_valid),
        .i_result(i_result), .i_calc_complete(i_calc_complete), .o_busy(o_busy),
        .o_error(o_error), .o_success(o_success)
    );

    typedef struct {logic [15:0] addr; logic [63:0] data;} wr_t;
    typedef struct {logic [63:0] data; logic last; logic [7:0] len; logic [7:0] flow;} rx_t;
    typedef struct {
        int fnum; int bad; int rmode; int nres; int succ_k;
        int exp_words; int exp_lasts; logic exp_err; logic exp_succ;
    } vec_t;

    logic [63:0] mem [0:65535];
    logic        host_we = 1'b0;
    logic [15:0] host_addr;
    logic [63:0] host_din;
    wr_t         wr_q[$];
    wr_t         wr_e;
    int          bad_we = 0;

    // BRAM: host port A writes, DUT port B read-first with write logging
    always @(posedge clk) begin
        if (host_we) mem[host_addr] <= host_din;
        if (o_bram_en) begin
            if (o_bram_we != 8'h00) begin
                mem[o_bram_addr] <= o_bram_din;
                wr_e.addr = o_bram_addr;
                wr_e.data = o_bram_din;
                wr_q.push_back(wr_e);
            end
            bram_dout <= mem[o_bram_addr];
        end
        if (o_bram_we != 8'h00 && (o_bram_we != 8'hFF || !o_bram_en)) bad_we++;
    end

    int ready_mode = 0;
    // Ready driver: always high or random, changed just after each edge
    always @(posedge clk) begin
        #1;
        i_data_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    rx_t  rx_q[$];
    rx_t  prev;
    logic prev_stall = 1'b0;
    logic got_valid = 1'b0;
    int   stall_err = 0;
    int   lat_run = 0;
    int   first_lat = 0;

    // Monitor: handshakes, stall stability, busy-to-first-valid latency
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            lat_run    = 0;
            got_valid  = 1'b0;
        end else begin
            if (prev_stall && (!o_data_valid || o_data != prev.data || o_data_last != prev.last ||
                               o_data_len != prev.len || o_flow_idx != prev.flow))
                stall_err++;
            prev_stall = o_data_valid && !i_data_ready;
            prev.data  = o_data;
            prev.last  = o_data_last;
            prev.len   = o_data_len;
            prev.flow  = o_flow_idx;
            if (o_data_valid && i_data_ready) rx_q.push_back(prev);
            if (!o_busy) begin
                lat_run   = 0;
                got_valid = 1'b0;
            end else if (!got_valid) begin
                if (o_data_valid) begin
                    got_valid = 1'b1;
                    first_lat = lat_run;
                end else begin
                    lat_run++;
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [15:0] a, input logic [63:0] d);
        host_we   = 1'b1;
        host_addr = a;
        host_din  = d;
        tick();
        host_we   = 1'b0;
    endtask

    function automatic logic [63:0] pay(input int p, input int w);
        return {16'hDA7A, 16'(p), 16'h0000, 16'(w)};
    endfunction

    function automatic logic [7:0] lenf(input int p);
        return 8'(8'h10 + p);
    endfunction

    function automatic logic [63:0] rval(input int k, input int sk);
        return (k == sk) ? SUCC : (64'h0123_0000_0000_0000 | 64'(k));
    endfunction

    function automatic bit mbox_cleared(input int from);
        for (int i = from; i < wr_q.size(); i++)
            if (wr_q[i].addr == 16'h0000) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load_batch(input int fnum, input int bad);
        int npk;
        logic [63:0] hdr;
        npk = (fnum + 1) * PPF;
        for (int p = 0; p < npk; p++) begin
            hdr        = 64'h0;
            hdr[63:48] = 16'hBEEF;
            hdr[7:0]   = (p == bad) ? 8'h54 : 8'h55;
            hdr[39:32] = lenf(p);
            host_wr(16'(1 + p * (PW + 1)), hdr);
            for (int w = 0; w < PW; w++) host_wr(16'(2 + p * (PW + 1) + w), pay(p, w));
        end
        host_wr(16'h0000, {40'h0, 8'(fnum), 8'hA5, 8'h55});
    endtask

    vec_t vecs[4];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int rx0, wr0, se0, bw0, n, lasts, mism, t, nw;
        logic [63:0] m0;
        rx_t r;

        vecs[0] = '{0, -1, 0, 3,  1,  35,  5, 1'b0, 1'b1};
        vecs[1] = '{0, -1, 1, 2, -1,  35,  5, 1'b0, 1'b0};
        vecs[2] = '{2, -1, 0, 5, -1, 105, 15, 1'b0, 1'b0};
        vecs[3] = '{0,  3, 1, 0, -1,  21,  3, 1'b1, 1'b0};

        rst = 1'b1;
        i_result_valid  = 1'b0;
        i_result        = '0;
        i_calc_complete = 1'b0;
        host_wr(16'h0000, 64'h0);
        tick();
        tick();
        @(negedge clk);
        check("reset_ctrl", {o_data_valid, o_data_last, o_bram_en, o_bram_we, o_busy, o_error, o_success}, 0);
        check("reset_data", o_data, 0);
        check("reset_fields", {o_data_len, o_flow_idx, o_flow_num, o_bram_addr}, 0);
        check("reset_din", o_bram_din, 0);

        for (int vi = 0; vi < 4; vi++) begin
            v = vecs[vi];
            rst = 1'b1;
            ready_mode = v.rmode;
            tick();
            load_batch(v.fnum, v.bad);
            rx0 = rx_q.size();
            wr0 = wr_q.size();
            se0 = stall_err;
            bw0 = bad_we;
            rst = 1'b0;

            t = 0;
            while ((rx_q.size() - rx0) < v.exp_words && t < 4000) begin tick(); t++; end
            if (!v.exp_err) begin
                for (int k = 0; k < v.nres; k++) begin
                    i_result_valid  = 1'b1;
                    i_result        = rval(k, v.succ_k);
                    i_calc_complete = (k == v.nres - 1);
                    tick();
                    i_result_valid  = 1'b0;
                    tick();
                end
                i_calc_complete = 1'b1;
            end
            while (!mbox_cleared(wr0) && t < 4500) begin tick(); t++; end
            i_calc_complete = 1'b0;
            for (int i = 0; i < 10; i++) tick();

            check($sformatf("v%0d_done", vi), t < 4500, 1);
            n = rx_q.size() - rx0;
            check($sformatf("v%0d_words", vi), n, v.exp_words);
            lasts = 0;
            mism  = 0;
            for (int i = 0; i < n && i < v.exp_words; i++) begin
                r = rx_q[rx0 + i];
                if (r.last) lasts++;
                if (r.data !== pay(i / PW, i % PW) || r.last !== (i % PW == PW - 1) ||
                    r.len !== lenf(i / PW) || r.flow !== 8'(i / PW / PPF))
                    mism++;
            end
            check($sformatf("v%0d_lasts", vi), lasts, v.exp_lasts);
            check($sformatf("v%0d_seq_mismatches", vi), mism, 0);
            check($sformatf("v%0d_error", vi), o_error, v.exp_err);
            check($sformatf("v%0d_success", vi), o_success, v.exp_succ);
            check($sformatf("v%0d_flow_num", vi), o_flow_num, v.fnum);
            check($sformatf("v%0d_busy_idle", vi), {o_busy, o_data_valid}, 0);
            check($sformatf("v%0d_first_lat", vi), first_lat, 3);
            nw = wr_q.size() - wr0;
            check($sformatf("v%0d_write_count", vi), nw, v.exp_err ? 1 : v.nres + 1);
            mism = 0;
            for (int k = 0; k < v.nres && (wr0 + k) < wr_q.size(); k++)
                if (wr_q[wr0 + k].addr !== 16'(32'hFFFC + k % 4) || wr_q[wr0 + k].data !== rval(k, v.succ_k))
                    mism++;
            check($sformatf("v%0d_result_writes", vi), mism, 0);
            check($sformatf("v%0d_last_write_mbox", vi),
                  (nw > 0) && wr_q[wr_q.size() - 1].addr == 16'h0 && wr_q[wr_q.size() - 1].data == 64'h0, 1);
            m0 = mem[0];
            check($sformatf("v%0d_mailbox", vi), m0, 0);
            check($sformatf("v%0d_stall_errs", vi), stall_err - se0, 0);
            check($sformatf("v%0d_bad_we", vi), bad_we - bw0, 0);
        end

        // Reset in the middle of streaming, then an out-of-state result strobe
        rst = 1'b1;
        ready_mode = 0;
        tick();
        load_batch(0, -1);
        rx0 = rx_q.size();
        rst = 1'b0;
        t = 0;
        while ((rx_q.size() - rx0) < 10 && t < 500) begin tick(); t++; end
        check("rstmid_reached_stream", t < 500, 1);
        wr0 = wr_q.size();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rstmid_ctrl", {o_data_valid, o_data_last, o_bram_en, o_bram_we, o_busy, o_error, o_success}, 0);
        check("rstmid_data", o_data, 0);
        check("rstmid_fields", {o_data_len, o_flow_idx, o_flow_num, o_bram_addr}, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        i_result_valid = 1'b1;
        i_result       = SUCC;
        tick();
        i_result_valid = 1'b0;
        tick();
        check("stray_result_success", o_success, 1);
        check("rstmid_no_writes", wr_q.size() - wr0, 0);
        m0 = mem[0];
        check("rstmid_mailbox_kept", m0[7:0], 8'h55);

        rst = 1'b1;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
